nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder built around one instance of the existing 4-bit KoggeStone adder (ports A, B, Cin, Sum, Cout).
- Processes one nibble per clock, least-significant first, and registers the carry between nibbles.
- Sits upstream of the 4-bit adder: it slices operands and sequences carries into it.
- Ready/valid handshakes on both sides; serves area-constrained datapaths that need wide sums.

---
 rtl/nibble_serial_adder_if.sv | 34 +++
 rtl/nibble_serial_adder.sv | 164 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle for nibble_serial_adder.
// Ovf is present only when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             Ovf;
`endif

  modport master (
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    input  Ovf,
`endif
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Cout
  );

  modport slave (
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output Ovf,
`endif
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Cout
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams one nibble per clock through a 4-bit Kogge-Stone core.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the two's-complement overflow output Ovf.

// 4-bit Kogge-Stone adder; carry-in is folded into the bit-0 generate term.
module kogge_stone_adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [3:0] p;
  logic [3:0] g0;
  logic [3:0] g1;
  logic [3:0] g2;
  logic       p1_2;
  logic       p1_3;

  assign p     = A ^ B;
  assign g0    = {A[3:1] & B[3:1], (A[0] & B[0]) | (p[0] & Cin)};

  assign g1[0] = g0[0];
  assign g1[1] = g0[1] | (p[1] & g0[0]);
  assign g1[2] = g0[2] | (p[2] & g0[1]);
  assign g1[3] = g0[3] | (p[3] & g0[2]);
  assign p1_2  = p[2] & p[1];
  assign p1_3  = p[3] & p[2];

  assign g2[0] = g1[0];
  assign g2[1] = g1[1];
  assign g2[2] = g1[2] | (p1_2 & g1[0]);
  assign g2[3] = g1[3] | (p1_3 & g1[1]);

  assign Sum   = p ^ {g2[2:0], Cin};
  assign Cout  = g2[3];
endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_serial_adder_if.slave    bus,
  output logic                    busy
);
  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic                 accept_c;
  logic                 last_c;

  logic [NIB-1:0][3:0]  a_reg;
  logic [NIB-1:0][3:0]  b_reg;
  logic [NIB-1:0][3:0]  sum_q;
  logic                 carry_q;
  logic [IDXW-1:0]      idx;
  logic                 cout_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [3:0]           add_sum;
  logic                 add_cout;

  kogge_stone_adder4 u_ks (
    .A    (a_reg[idx]),
    .B    (b_reg[idx]),
    .Cin  (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and step decode
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    last_c     = (idx == IDXW'(NIB - 1));
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept_c   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_c) state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags follow the state being entered so they stay registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
      busy_q      <= (state_next != IDLE);
    end
  end

  // Operand capture and nibble sequencing; idx holds at NIB-1 rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      cout_q  <= 1'b0;
    end else if (accept_c) begin
      a_reg   <= bus.A;
      b_reg   <= bus.B;
      carry_q <= bus.Cin;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_q[idx] <= add_sum;
      carry_q    <= add_cout;
      if (last_c) cout_q <= add_cout;
      else        idx    <= idx + IDXW'(1);
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Carry into the MSB is recovered from the top operand bits and the new sum bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state == RUN) && last_c) begin
      ovf_q <= (a_reg[NIB-1][3] ^ b_reg[NIB-1][3] ^ add_sum[3]) ^ add_cout;
    end
  end

  assign bus.Ovf = ovf_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): vector table plus handshake corner sequences.
module tb_nibble_serial_adder;
  localparam int unsigned WIDTH = 16;
  localparam int          NIB   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  int n_cmp  = 0;
  int n_fail = 0;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands in IDLE, complete the accept edge, then scramble the inputs
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic ordy);
    @(negedge clk);
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.A         = a;
    bus.B         = b;
    bus.Cin       = cin;
    bus.in_valid  = 1'b1;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = ~a;
    bus.B        = ~b;
    bus.Cin      = ~cin;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_result(input int lat0, output int lat);
    lat = lat0;
    while (!bus.out_valid && lat <= 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] s, input logic c,
                              input logic o);
    check({name, "_sum"}, 32'(bus.Sum), 32'(s));
    check({name, "_cout"}, 32'(bus.Cout), 32'(c));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check({name, "_ovf"}, 32'(bus.Ovf), 32'(o));
`else
    if (o === 1'bx) $display("note: unexpected x in ovf expectation for %s", name);
`endif
  endtask

  // Release the result and confirm IDLE is re-entered on the following edge
  task automatic finish_op(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({name, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    check({name, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start_op(v.a, v.b, v.cin, 1'b1);
    wait_result(0, lat);
    check({v.name, "_latency"}, 32'(lat), 32'(NIB));
    check_result(v.name, v.sum, v.cout, v.ovf);
    finish_op(v.name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;

    vecs[0] = '{"d6b5_3a4b",  16'hD6B5, 16'h3A4B, 1'b0, 16'h1100, 1'b1, 1'b0};
    vecs[1] = '{"ffff_cin",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"zero",       16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{"all_ones",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{"neg_ovf",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{"pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{"cin_only",   16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0};
    vecs[7] = '{"abcd_1111",  16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    vecs[8] = '{"ffff_0001",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{"mixed",      16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_result("rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: result and flags must hold while out_ready stays low
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_result(0, lat);
    check("bp_latency", 32'(lat), 32'(NIB));
    for (int k = 0; k < 3; k++) begin
      check_result("bp_hold", 16'h5555, 1'b0, 1'b0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    check_result("bp_final", 16'h5555, 1'b0, 1'b0);
    finish_op("bp");

    // in_valid pulsed during RUN must not disturb the in-flight operation
    start_op(16'h0001, 16'h0001, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    bus.A        = 16'hAAAA;
    bus.B        = 16'hAAAA;
    @(posedge clk);
    #1;
    check("ign_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    wait_result(1, lat);
    check("ign_latency", 32'(lat), 32'(NIB));
    check_result("ign", 16'h0002, 1'b0, 1'b0);
    finish_op("ign");

    // Asynchronous reset after two RUN cycles discards the partial result
    start_op(16'h1111, 16'h2222, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check_result("mrst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{"post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
